serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial multi-cycle subtractor: computes D = A - B - BI one bit per clock, LSB first.
//  One full-subtractor cell plus a borrow flop, iterated WIDTH times; trades latency for area.
//  Sits beside the ripple adder in the ALU datapath as the low-area SUB/compare unit.
//  Start/done handshake with the control unit.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal range 1..64
// PORTS
//  CLK    in   1      single clock; all state updates on rising edge
//  RST    in   1      synchronous reset, active-high
//  START  in   1      request: sample A, B, BI and begin a subtraction
//  A      in   WIDTH  minuend, sampled only on an accepted START
//  B      in   WIDTH  subtrahend, sampled only on an accepted START
//  BI     in   1      borrow in, sampled only on an accepted START
//  D      out  WIDTH  difference; updates only on completion
//  BO     out  1      borrow out (1 = unsigned A < B + BI); updates only on completion
//  BUSY   out  1      high while a subtraction is in progress
//  DONE   out  1      one-cycle pulse: D/BO just updated
// BEHAVIOUR
//  - Reset: RST high at an edge -> state IDLE; D=0, BO=0, BUSY=0, DONE=0.
//    Counter, borrow flop and operand shift registers are cleared.
//    Reset wins over every other event, including an operation in progress.
//  - FSM states: IDLE, RUN, FIN.
//    IDLE -START-> RUN. RUN -(count==WIDTH-1)-> FIN. FIN -START-> RUN, else IDLE.
//  - Accept: START is accepted only in IDLE or FIN; it is ignored in RUN (no queueing).
//    On accept: latch A, B into shift regs, borrow<=BI, count<=0.
//  - RUN, per cycle, using a=A_sr[0], b=B_sr[0], c=borrow:
//    d = a^b^c; c' = (~a&b) | (~(a^b)&c).
//    d shifts into the MSB of the result shift reg; A_sr, B_sr shift right; count++.
//  - Completion (RUN->FIN edge): D<=result reg, BO<=final borrow, DONE=1 during FIN.
//    BUSY=1 exactly in RUN; DONE=1 exactly in FIN.
//  - Latency: START accepted at edge k -> BUSY high cycles k+1..k+WIDTH.
//    DONE high, D/BO valid, in cycle k+WIDTH+1.
//  - D/BO hold their value from completion until the next completion or reset.
//    They never show partial results.
//  - Back-to-back: START during FIN is accepted. DONE still pulses that cycle.
//    The next DONE follows WIDTH+1 cycles later (throughput 1 op per WIDTH+1 cycles).
//  - WIDTH=1: RUN lasts exactly 1 cycle.
//  - Arithmetic is modulo 2^WIDTH; BO is the true unsigned borrow.
// CONFIGURATION
//  SERIAL_SUB_FLAGS_EN defined: adds outputs Z (1 bit) and V (1 bit), updated with D/BO.
//    Z = (D == 0).
//    V = signed overflow = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]); the MSBs are latched at accept.
//    Both are 0 on reset.
//  SERIAL_SUB_FLAGS_EN undefined: Z and V ports and their logic are absent.
//    All other behaviour is identical.
// TESTING (WIDTH=32)
//  1. Reset, then A=5, B=3, BI=0, START 1 cycle.
//     -> BUSY 32 cycles; DONE at cycle k+33; D=0x00000002, BO=0, Z=0, V=0.
//  2. A=3, B=5, BI=0 -> D=0xFFFFFFFE, BO=1, V=0.
//     Then A=0, B=0, BI=1 -> D=0xFFFFFFFF, BO=1.
//  3. A=0x80000000, B=1 -> D=0x7FFFFFFF, BO=0, V=1.
//     Then A=B=0x1234ABCD -> D=0, Z=1, BO=0.
//  4. Pulse START with new operands at cycle k+10 of a run.
//     -> ignored; result is the first op's; no extra DONE.
//  5. Assert RST at cycle k+15 of a run.
//     -> next cycle D=0, BO=0, BUSY=0, DONE=0, state IDLE; a fresh START completes correctly.
//  6. Hold START high continuously with changing operands.
//     -> DONE every 33 cycles; each result matches the operands sampled in the prior FIN/IDLE.
//     -> Random 1000-op check against A-B-BI reference model.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor computing D = A - B - BI, LSB first,
// one full-subtractor cell per clock over WIDTH cycles, with a START/DONE
// handshake. Define SERIAL_SUB_FLAGS_EN to add the Z (zero) and V (signed
// overflow) result flags; without it those ports and their logic are absent.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             BUSY,
  output logic             DONE
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             Z,
  output logic             V
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic [WIDTH-1:0] res_next_s;
  logic [CW-1:0]    count_r;
  logic             borrow_r;
  logic             borrow_next_s;
  logic             d_bit_s;
  logic             last_s;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             a_msb_r;
  logic             b_msb_r;
`endif

  // Full-subtractor cell: returns {borrow_out, difference} for a - b - c.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic c);
    logic diff;
    logic bout;
    diff = a ^ b ^ c;
    bout = (~a & b) | (~(a ^ b) & c);
    return {bout, diff};
  endfunction

  // One subtraction step on the current LSBs, plus the result word after this step.
  always_comb begin
    {borrow_next_s, d_bit_s} = full_sub(a_sr_r[0], b_sr_r[0], borrow_r);
    res_next_s               = res_sr_r >> 1'b1;
    res_next_s[WIDTH-1]      = d_bit_s;
    last_s                   = (count_r == CW'(WIDTH - 1));
  end

  // Control FSM, operand/result shifting and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      a_sr_r   <= {WIDTH{1'b0}};
      b_sr_r   <= {WIDTH{1'b0}};
      res_sr_r <= {WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
      borrow_r <= 1'b0;
      D        <= {WIDTH{1'b0}};
      BO       <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      Z        <= 1'b0;
      V        <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_FIN: begin
          // DONE lasts exactly the FIN cycle; a new START may be taken here.
          DONE <= 1'b0;
          if (START) begin
            state_r  <= ST_RUN;
            BUSY     <= 1'b1;
            a_sr_r   <= A;
            b_sr_r   <= B;
            borrow_r <= BI;
            count_r  <= {CW{1'b0}};
            res_sr_r <= {WIDTH{1'b0}};
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_r  <= A[WIDTH-1];
            b_msb_r  <= B[WIDTH-1];
`endif
          end else begin
            state_r <= ST_IDLE;
            BUSY    <= 1'b0;
          end
        end
        ST_RUN: begin
          a_sr_r   <= a_sr_r >> 1'b1;
          b_sr_r   <= b_sr_r >> 1'b1;
          borrow_r <= borrow_next_s;
          res_sr_r <= res_next_s;
          if (last_s) begin
            // Publish the whole result at once so D/BO never show partial values.
            state_r <= ST_FIN;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            D       <= res_next_s;
            BO      <= borrow_next_s;
`ifdef SERIAL_SUB_FLAGS_EN
            Z       <= (res_next_s == {WIDTH{1'b0}});
            V       <= (a_msb_r != b_msb_r) && (d_bit_s != a_msb_r);
`endif
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=32): directed vectors with
// hand-computed results, mid-run START and RST cases, and a continuous-START
// stream checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 32;

  logic         CLK;
  logic         RST;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BI;
  logic [W-1:0] D;
  logic         BO;
  logic         BUSY;
  logic         DONE;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         Z;
  logic         V;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .BI    (BI),
    .D     (D),
    .BO    (BO),
    .BUSY  (BUSY),
    .DONE  (DONE)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .Z     (Z),
    .V     (V)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         v;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [W-1:0] last_d = '0;
  logic         last_bo = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count rising edges so the monitor can check completion latency.
  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t e;
    logic [W:0] diff;
    diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.d   = diff[W-1:0];
    e.bo  = diff[W];
    e.z   = (diff[W-1:0] == '0);
    e.v   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    e.due = 0;
    return e;
  endfunction

  // Monitor: pop and compare on every DONE; otherwise results must hold.
  always @(negedge CLK) begin
    if (RST) begin
      q.delete();
      last_d  = '0;
      last_bo = 1'b0;
    end else if (DONE) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(DONE), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("d", 64'(D), 64'(e.d));
        chk("bo", 64'(BO), 64'(e.bo));
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("busy_in_fin", 64'(BUSY), 64'd0);
`ifdef SERIAL_SUB_FLAGS_EN
        chk("z", 64'(Z), 64'(e.z));
        chk("v", 64'(V), 64'(e.v));
`endif
      end
      last_d  = D;
      last_bo = BO;
    end else begin
      chk("d_hold", 64'(D), 64'(last_d));
      chk("bo_hold", 64'(BO), 64'(last_bo));
    end
  end

  // Wait until the DUT can accept, then present one START with its expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input logic [W-1:0] ed, input logic ebo, input logic ez, input logic ev);
    int n;
    exp_t e;
    n = 0;
    @(negedge CLK);
    while (BUSY !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) chk("issue_timeout", 64'(BUSY), 64'd0);
    A = a; B = b; BI = bi; START = 1'b1;
    e.d = ed; e.bo = ebo; e.z = ez; e.v = ev; e.due = cyc + W + 1;
    q.push_back(e);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(negedge CLK);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk({tag, "_d"}, 64'(D), 64'd0);
    chk({tag, "_bo"}, 64'(BO), 64'd0);
    chk({tag, "_busy"}, 64'(BUSY), 64'd0);
    chk({tag, "_done"}, 64'(DONE), 64'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    chk({tag, "_z"}, 64'(Z), 64'd0);
    chk({tag, "_v"}, 64'(V), 64'd0);
`endif
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int acc;
    int guard;
    exp_t e;
    RST = 1'b1; START = 1'b0; A = '0; B = '0; BI = 1'b0;
    do_reset("reset");

    // Test 1: 5 - 3 with BUSY-length check.
    issue(32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (DONE === 1'b1) break;
      if (BUSY === 1'b1) busy_cnt++;
      @(negedge CLK);
    end
    chk("busy_cycles", 64'(busy_cnt), 64'd32);
    drain();

    // Tests 2 and 3: borrow, borrow-in, overflow, zero results.
    issue(32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    issue(32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    issue(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    issue(32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    drain();

    // Test 4: START during RUN is ignored.
    issue(32'd100, 32'd1, 1'b0, 32'h0000_0063, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge CLK);
    A = 32'd7; B = 32'd9; BI = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    drain();
    repeat (40) @(negedge CLK);

    // Test 5: reset mid-run, then a fresh operation.
    issue(32'd1, 32'd1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (13) @(negedge CLK);
    do_reset("midrun_reset");
    chk("queue_flushed", 64'(q.size()), 64'd0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    drain();

    // Test 6: START held high with changing operands, checked by model.
    acc = 0;
    guard = 0;
    while (acc < 1000 && guard < 40000) begin
      @(negedge CLK);
      A = $urandom; B = $urandom; BI = 1'($urandom_range(0, 1));
      if (acc < 3) begin
        A = 32'd10 << acc; B = 32'd3; BI = 1'b0;
      end
      START = 1'b1;
      if (BUSY === 1'b0) begin
        e = model(A, B, BI);
        e.due = cyc + W + 1;
        q.push_back(e);
        acc++;
      end
      guard++;
    end
    if (acc < 1000) chk("stream_timeout", 64'(acc), 64'd1000);
    @(negedge CLK);
    START = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
